std_rst_seq: RTL and testbench

Reset release sequencer for arrays of async-reset, active-low flops. Synchronizes the deassertion of a global asynchronous reset, then releases NR downstream reset domains one at a time in index order with a programmable gap and an optional per-domain acknowledge handshake. A synchronous soft-reset request re-asserts every domain and re-runs the sequence. It sits between the board or system reset and the `nreset` inputs of datapath flop banks.

---
 rtl/std_rst_seq_if.sv | 34 +++
 rtl/std_rst_seq.sv | 215 +++++++++++++++++++++
 tb/tb_std_rst_seq.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/std_rst_seq_if.sv
// std_rst_seq_if: control and status bundle of the reset release sequencer.
// The master side is the sequencer. It takes the soft-reset request and the
// per-domain acknowledges, and it drives the domain resets and the status.
// The slave side is the system that observes and controls the sequencer.
interface std_rst_seq_if #(
  parameter int NR = 4
);
  localparam int SW = $clog2(NR + 1);

  logic          sreq;
  logic [NR-1:0] ack;
  logic [NR-1:0] nrst_out;
  logic [SW-1:0] stage;
  logic          done;
  logic [NR-1:0] err;

  modport master (
    input  sreq,
    input  ack,
    output nrst_out,
    output stage,
    output done,
    output err
  );

  modport slave (
    output sreq,
    output ack,
    input  nrst_out,
    input  stage,
    input  done,
    input  err
  );
endinterface

// File: rtl/std_rst_seq.sv
// std_rst_seq: reset release sequencer.
// - Synchronizes the deassertion of nreset.
// - Holds every domain in reset for DLY cycles.
// - Releases domains 0..NR-1 one at a time, with a DLY-cycle gap after each release.
// Optional feature macro: STD_RST_SEQ_ACK_EN.
// - When defined, the release of domain i+1 also waits for ack[i], for at most TMO cycles.
// - On timeout, the sticky flag err[i] is set and the sequence continues anyway.
// - When undefined, ack is ignored and err reads 0.
module std_rst_seq #(
  parameter int NR   = 4,
  parameter int SYNC = 2,
  parameter int DLY  = 16,
  parameter int TMO  = 64
) (
  input  logic          clk,
  input  logic          nreset,
  std_rst_seq_if.master bus
);
  localparam int SW   = $clog2(NR + 1);
  localparam int CMAX = (DLY > TMO) ? DLY : TMO;
  localparam int CW   = $clog2(CMAX + 1);
  // The FSM's exit from SYNC acts as the last synchronizer stage.
  // The chain itself therefore holds SYNC-1 flops.
  localparam int SCW  = SYNC - 1;

  localparam logic [CW-1:0] DLY_LAST  = CW'(DLY - 1);
  localparam logic [SW-1:0] STAGE_ALL = SW'(NR);
`ifdef STD_RST_SEQ_ACK_EN
  localparam logic [CW-1:0] TMO_LAST  = CW'(TMO - 1);
`endif

  typedef enum logic [2:0] {
    ST_SYNC = 3'd0,
    ST_HOLD = 3'd1,
    ST_GAP  = 3'd2,
`ifdef STD_RST_SEQ_ACK_EN
    ST_WAIT = 3'd4,
`endif
    ST_RUN  = 3'd3
  } state_t;

  state_t        state_q, state_d;
  logic [SCW-1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NR-1:0] nrst_out_q, nrst_out_d;
  logic [SW-1:0] stage_q, stage_d;
  logic          done_q, done_d;
  logic [NR-1:0] rel_nrst_s;
  logic [SW-1:0] rel_stage_s;
`ifdef STD_RST_SEQ_ACK_EN
  logic [NR-1:0] err_q, err_d;
  logic [NR-1:0] cur_sel_s;
  logic          ack_cur_s;
`endif

  // Domains are released strictly in order, so nrst_out is a thermometer code.
  // Each release shifts one more 1 in from the bottom.
  assign sync_d      = (sync_q << 1) | SCW'(1'b1);
  assign rel_nrst_s  = (nrst_out_q << 1) | NR'(1'b1);
  assign rel_stage_s = stage_q + SW'(1'b1);

`ifdef STD_RST_SEQ_ACK_EN
  // Select the domain whose ack gates the next release.
  // Domain i is the last released one, so stage equals i+1.
  // ack[NR-1] never gates anything.
  always_comb begin
    cur_sel_s = '0;
    for (int i = 0; i < NR - 1; i++) begin
      cur_sel_s[i] = (stage_q == SW'(i + 1));
    end
    ack_cur_s = |(cur_sel_s & bus.ack);
  end
`endif

  // Next-state and output computation for the sequencer FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nrst_out_d = nrst_out_q;
    stage_d    = stage_q;
    done_d     = done_q;
`ifdef STD_RST_SEQ_ACK_EN
    err_d      = err_q;
`endif
    if (bus.sreq && (state_q != ST_SYNC)) begin
      // Soft reset: re-assert every domain and restart the hold phase.
      state_d    = ST_HOLD;
      cnt_d      = '0;
      nrst_out_d = '0;
      stage_d    = '0;
      done_d     = 1'b0;
    end else begin
      case (state_q)
        ST_SYNC: begin
          cnt_d = '0;
          if (sync_q[SCW-1]) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_SYNC;
          end
        end
        ST_HOLD: begin
          if (cnt_q == DLY_LAST) begin
            state_d    = ST_GAP;
            cnt_d      = '0;
            nrst_out_d = rel_nrst_s;
            stage_d    = rel_stage_s;
          end else begin
            cnt_d = cnt_q + CW'(1'b1);
          end
        end
        ST_GAP: begin
          if (cnt_q == DLY_LAST) begin
            cnt_d = '0;
            if (stage_q == STAGE_ALL) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
`ifdef STD_RST_SEQ_ACK_EN
            end else if (ack_cur_s) begin
              state_d    = ST_GAP;
              nrst_out_d = rel_nrst_s;
              stage_d    = rel_stage_s;
            end else begin
              state_d = ST_WAIT;
            end
`else
            end else begin
              state_d    = ST_GAP;
              nrst_out_d = rel_nrst_s;
              stage_d    = rel_stage_s;
            end
`endif
          end else begin
            cnt_d = cnt_q + CW'(1'b1);
          end
        end
`ifdef STD_RST_SEQ_ACK_EN
        ST_WAIT: begin
          if (ack_cur_s) begin
            state_d    = ST_GAP;
            cnt_d      = '0;
            nrst_out_d = rel_nrst_s;
            stage_d    = rel_stage_s;
          end else if (cnt_q == TMO_LAST) begin
            // A silent domain must not stall the rest of the system.
            // Flag the timeout and release the next domain anyway.
            state_d    = ST_GAP;
            cnt_d      = '0;
            err_d      = err_q | cur_sel_s;
            nrst_out_d = rel_nrst_s;
            stage_d    = rel_stage_s;
          end else begin
            cnt_d = cnt_q + CW'(1'b1);
          end
        end
`endif
        ST_RUN: begin
          cnt_d  = '0;
          done_d = 1'b1;
        end
        default: begin
          state_d    = ST_SYNC;
          cnt_d      = '0;
          nrst_out_d = '0;
          stage_d    = '0;
          done_d     = 1'b0;
        end
      endcase
    end
  end

  // Synchronizer chain for the deassertion edge of nreset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // State, counter and registered outputs. All are cleared asynchronously by nreset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_SYNC;
      cnt_q      <= '0;
      nrst_out_q <= '0;
      stage_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nrst_out_q <= nrst_out_d;
      stage_q    <= stage_d;
      done_q     <= done_d;
    end
  end

`ifdef STD_RST_SEQ_ACK_EN
  // Sticky timeout flags. Only nreset clears them.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end
  assign bus.err = err_q;
`else
  assign bus.err = '0;
`endif

  assign bus.nrst_out = nrst_out_q;
  assign bus.stage    = stage_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_std_rst_seq.sv
// tb_std_rst_seq: randomized and directed bench for std_rst_seq.
// The expected outputs come from event times computed per soft-reset epoch.
// For each domain the reference derives a release edge and a timeout edge from the ack table.
module tb_std_rst_seq;
  localparam int NR   = 4;
  localparam int SYNC = 2;
  localparam int DLY  = 4;
  localparam int TMO  = 8;
  localparam int SW   = $clog2(NR + 1);
  localparam int MAXE = 200;
  localparam int INF  = 1000000;
`ifdef STD_RST_SEQ_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic nreset = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [NR-1:0] ack_tab  [0:MAXE];
  logic          sreq_tab [0:MAXE];
  logic [NR-1:0] exp_nrst [0:MAXE];
  logic [SW-1:0] exp_stage[0:MAXE];
  logic          exp_done [0:MAXE];
  logic [NR-1:0] exp_err  [0:MAXE];
  logic [NR-1:0] obs_nrst [0:MAXE];
  logic [SW-1:0] obs_stage[0:MAXE];
  logic          obs_done [0:MAXE];
  logic [NR-1:0] obs_err  [0:MAXE];

  std_rst_seq_if #(.NR(NR)) bus ();

  std_rst_seq #(.NR(NR), .SYNC(SYNC), .DLY(DLY), .TMO(TMO)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_tabs();
    for (int e = 0; e <= MAXE; e++) begin
      ack_tab[e]  = '0;
      sreq_tab[e] = 1'b0;
    end
  endtask

  // Reference model.
  // A soft-reset edge starts a new epoch. Releases and timeouts are then derived from the epoch base.
  function automatic void build_expect(input int n);
    int base, nxt, g, r, t_done, cnt;
    int t_rel [NR];
    int t_to  [NR];
    logic [NR-1:0] carry, ev;
    carry = '0;
    for (int e = 0; e < SYNC && e <= n; e++) begin
      exp_nrst[e] = '0; exp_stage[e] = '0; exp_done[e] = 1'b0; exp_err[e] = '0;
    end
    base = SYNC;
    while (base <= n) begin
      nxt = n + 1;
      for (int k = n; k > base; k--) if (sreq_tab[k]) nxt = k;
      for (int i = 0; i < NR; i++) t_to[i] = INF;
      t_rel[0] = base + DLY;
      for (int i = 0; i < NR - 1; i++) begin
        g = t_rel[i] + DLY;
        if (ACK_EN) begin
          r = INF;
          for (int w = 0; w <= TMO; w++)
            if (r == INF && g + w <= MAXE && ack_tab[g + w][i]) r = g + w;
          if (r == INF) begin
            t_to[i] = g + TMO;
            r = g + TMO;
          end
          t_rel[i + 1] = r;
        end else begin
          t_rel[i + 1] = g;
        end
      end
      t_done = t_rel[NR - 1] + DLY;
      for (int e = base; e < nxt; e++) begin
        cnt = 0;
        ev = carry;
        for (int i = 0; i < NR; i++) begin
          exp_nrst[e][i] = (t_rel[i] <= e);
          if (t_rel[i] <= e) cnt++;
          if (t_to[i] <= e) ev[i] = 1'b1;
        end
        exp_stage[e] = SW'(cnt);
        exp_done[e]  = (e >= t_done);
        exp_err[e]   = ev;
      end
      for (int i = 0; i < NR; i++) if (t_to[i] < nxt) carry[i] = 1'b1;
      base = nxt;
    end
  endfunction

  // Reset and release nreset at a falling edge, so the next rising edge is edge 1.
  // Replay the stimulus tables and record the outputs #1 after each edge.
  task automatic drive_scenario(input int n);
    nreset   = 1'b0;
    bus.sreq = 1'b0;
    bus.ack  = '0;
    #17;
    @(negedge clk);
    nreset = 1'b1;
    #1;
    obs_nrst[0] = bus.nrst_out; obs_stage[0] = bus.stage;
    obs_done[0] = bus.done;     obs_err[0]   = bus.err;
    for (int e = 1; e <= n; e++) begin
      bus.ack  = ack_tab[e];
      bus.sreq = sreq_tab[e];
      @(posedge clk);
      #1;
      obs_nrst[e] = bus.nrst_out; obs_stage[e] = bus.stage;
      obs_done[e] = bus.done;     obs_err[e]   = bus.err;
    end
    bus.sreq = 1'b0;
  endtask

  task automatic test_reset();
    nreset   = 1'b0;
    bus.sreq = 1'b1;
    bus.ack  = 4'b1111;
    #3;
    total++;
    if ({bus.nrst_out, bus.stage, bus.done, bus.err} !== {NR'(0), SW'(0), 1'b0, NR'(0)}) begin
      bad++;
      $display("FAIL reset_async: got nrst=%b stage=%0d done=%b err=%b want all zero",
               bus.nrst_out, bus.stage, bus.done, bus.err);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.nrst_out, bus.stage, bus.done} !== {NR'(0), SW'(0), 1'b0}) begin
      bad++;
      $display("FAIL reset_clocked: got nrst=%b stage=%0d done=%b want all zero",
               bus.nrst_out, bus.stage, bus.done);
    end
    clear_tabs();
    drive_scenario(5);
    build_expect(5);
    for (int e = 0; e <= 5; e++) begin
      total++;
      if ({obs_nrst[e], obs_stage[e], obs_done[e], obs_err[e]} !== {exp_nrst[e], exp_stage[e], exp_done[e], exp_err[e]}) begin
        bad++;
        $display("FAIL reset_seq edge %0d: got %b/%0d/%b/%b want %b/%0d/%b/%b", e,
                 obs_nrst[e], obs_stage[e], obs_done[e], obs_err[e], exp_nrst[e], exp_stage[e], exp_done[e], exp_err[e]);
      end
    end
  endtask

  task automatic test_no_stall();
    int ev [6];
    logic [NR-1:0] nv [6];
    ev = '{5, 6, 10, 14, 18, 21};
    nv = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111};
    clear_tabs();
    for (int e = 0; e <= MAXE; e++) ack_tab[e] = 4'b1111;
    drive_scenario(26);
    build_expect(26);
    for (int e = 0; e <= 26; e++) begin
      total++;
      if ({obs_nrst[e], obs_stage[e], obs_done[e], obs_err[e]} !== {exp_nrst[e], exp_stage[e], exp_done[e], exp_err[e]}) begin
        bad++;
        $display("FAIL no_stall edge %0d: got %b/%0d/%b/%b want %b/%0d/%b/%b", e,
                 obs_nrst[e], obs_stage[e], obs_done[e], obs_err[e], exp_nrst[e], exp_stage[e], exp_done[e], exp_err[e]);
      end
    end
    for (int j = 0; j < 6; j++) begin
      total++;
      if (obs_nrst[ev[j]] !== nv[j]) begin
        bad++;
        $display("FAIL no_stall_edge%0d: got nrst=%b want %b", ev[j], obs_nrst[ev[j]], nv[j]);
      end
    end
    total++;
    if ({obs_done[21], obs_done[22], obs_stage[22]} !== {1'b0, 1'b1, SW'(4)}) begin
      bad++;
      $display("FAIL no_stall_done: got done21=%b done22=%b stage22=%0d want 0 1 4",
               obs_done[21], obs_done[22], obs_stage[22]);
    end
  endtask

  task automatic test_ack_stall();
    int r1, dn;
    r1 = ACK_EN ? 13 : 10;
    dn = ACK_EN ? 25 : 22;
    clear_tabs();
    for (int e = 0; e <= MAXE; e++) ack_tab[e] = (e >= 13) ? 4'b1111 : 4'b1110;
    drive_scenario(30);
    build_expect(30);
    for (int e = 0; e <= 30; e++) begin
      total++;
      if ({obs_nrst[e], obs_stage[e], obs_done[e], obs_err[e]} !== {exp_nrst[e], exp_stage[e], exp_done[e], exp_err[e]}) begin
        bad++;
        $display("FAIL ack_stall edge %0d: got %b/%0d/%b/%b want %b/%0d/%b/%b", e,
                 obs_nrst[e], obs_stage[e], obs_done[e], obs_err[e], exp_nrst[e], exp_stage[e], exp_done[e], exp_err[e]);
      end
    end
    total++;
    if ({obs_nrst[r1 - 1], obs_nrst[r1], obs_nrst[r1 + 4], obs_nrst[r1 + 8]} !== {4'b0001, 4'b0011, 4'b0111, 4'b1111}) begin
      bad++;
      $display("FAIL ack_stall_release: got %b %b %b %b want 0001 0011 0111 1111",
               obs_nrst[r1 - 1], obs_nrst[r1], obs_nrst[r1 + 4], obs_nrst[r1 + 8]);
    end
    total++;
    if ({obs_done[dn - 1], obs_done[dn], obs_err[dn]} !== {1'b0, 1'b1, 4'b0000}) begin
      bad++;
      $display("FAIL ack_stall_done: got done%0d=%b done%0d=%b err=%b want 0 1 0000",
               dn - 1, obs_done[dn - 1], dn, obs_done[dn], obs_err[dn]);
    end
  endtask

  task automatic test_ack_timeout();
    int r2;
    logic [NR-1:0] we;
    r2 = ACK_EN ? 22 : 14;
    we = ACK_EN ? 4'b0010 : 4'b0000;
    clear_tabs();
    for (int e = 0; e <= MAXE; e++) ack_tab[e] = 4'b1101;
    drive_scenario(34);
    build_expect(34);
    for (int e = 0; e <= 34; e++) begin
      total++;
      if ({obs_nrst[e], obs_stage[e], obs_done[e], obs_err[e]} !== {exp_nrst[e], exp_stage[e], exp_done[e], exp_err[e]}) begin
        bad++;
        $display("FAIL ack_timeout edge %0d: got %b/%0d/%b/%b want %b/%0d/%b/%b", e,
                 obs_nrst[e], obs_stage[e], obs_done[e], obs_err[e], exp_nrst[e], exp_stage[e], exp_done[e], exp_err[e]);
      end
    end
    total++;
    if ({obs_err[r2 - 1], obs_err[r2], obs_nrst[r2 - 1], obs_nrst[r2]} !== {4'b0000, we, 4'b0011, 4'b0111}) begin
      bad++;
      $display("FAIL ack_timeout_edge: got err=%b,%b nrst=%b,%b want 0000,%b 0011,0111",
               obs_err[r2 - 1], obs_err[r2], obs_nrst[r2 - 1], obs_nrst[r2], we);
    end
    total++;
    if ({obs_done[34], obs_err[34]} !== {1'b1, we}) begin
      bad++;
      $display("FAIL ack_timeout_final: got done=%b err=%b want 1 %b", obs_done[34], obs_err[34], we);
    end
  endtask

  task automatic test_sreq_pulse();
    logic [NR-1:0] we;
    we = ACK_EN ? 4'b0010 : 4'b0000;
    clear_tabs();
    for (int e = 0; e <= MAXE; e++) ack_tab[e] = 4'b1101;
    sreq_tab[40] = 1'b1;
    drive_scenario(50);
    build_expect(50);
    for (int e = 0; e <= 50; e++) begin
      total++;
      if ({obs_nrst[e], obs_stage[e], obs_done[e], obs_err[e]} !== {exp_nrst[e], exp_stage[e], exp_done[e], exp_err[e]}) begin
        bad++;
        $display("FAIL sreq_pulse edge %0d: got %b/%0d/%b/%b want %b/%0d/%b/%b", e,
                 obs_nrst[e], obs_stage[e], obs_done[e], obs_err[e], exp_nrst[e], exp_stage[e], exp_done[e], exp_err[e]);
      end
    end
    total++;
    if ({obs_done[39], obs_nrst[40], obs_done[40], obs_nrst[43], obs_nrst[44], obs_err[44]} !==
        {1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0001, we}) begin
      bad++;
      $display("FAIL sreq_pulse_points: got done39=%b nrst40=%b done40=%b nrst43=%b nrst44=%b err44=%b",
               obs_done[39], obs_nrst[40], obs_done[40], obs_nrst[43], obs_nrst[44], obs_err[44]);
    end
  endtask

  task automatic test_sreq_hold();
    clear_tabs();
    for (int e = 0; e <= MAXE; e++) ack_tab[e] = 4'b1111;
    for (int e = 30; e < 40; e++) sreq_tab[e] = 1'b1;
    drive_scenario(48);
    build_expect(48);
    for (int e = 0; e <= 48; e++) begin
      total++;
      if ({obs_nrst[e], obs_stage[e], obs_done[e], obs_err[e]} !== {exp_nrst[e], exp_stage[e], exp_done[e], exp_err[e]}) begin
        bad++;
        $display("FAIL sreq_hold edge %0d: got %b/%0d/%b/%b want %b/%0d/%b/%b", e,
                 obs_nrst[e], obs_stage[e], obs_done[e], obs_err[e], exp_nrst[e], exp_stage[e], exp_done[e], exp_err[e]);
      end
    end
    for (int e = 30; e <= 42; e++) begin
      total++;
      if ({obs_nrst[e], obs_done[e]} !== {4'b0000, 1'b0}) begin
        bad++;
        $display("FAIL sreq_hold_low edge %0d: got nrst=%b done=%b want 0000 0", e, obs_nrst[e], obs_done[e]);
      end
    end
    total++;
    if (obs_nrst[43] !== 4'b0001) begin
      bad++;
      $display("FAIL sreq_hold_release: got nrst43=%b want 0001", obs_nrst[43]);
    end
  endtask

  task automatic test_nreset_midgap();
    clear_tabs();
    for (int e = 0; e <= MAXE; e++) ack_tab[e] = 4'b1111;
    drive_scenario(12);
    total++;
    if (bus.stage !== SW'(2)) begin
      bad++;
      $display("FAIL midgap_stage: got stage=%0d want 2", bus.stage);
    end
    #3;
    nreset = 1'b0;
    #1;
    total++;
    if ({bus.nrst_out, bus.stage, bus.done, bus.err} !== {NR'(0), SW'(0), 1'b0, NR'(0)}) begin
      bad++;
      $display("FAIL midgap_async: got nrst=%b stage=%0d done=%b err=%b want all zero",
               bus.nrst_out, bus.stage, bus.done, bus.err);
    end
    drive_scenario(24);
    build_expect(24);
    for (int e = 0; e <= 24; e++) begin
      total++;
      if ({obs_nrst[e], obs_stage[e], obs_done[e], obs_err[e]} !== {exp_nrst[e], exp_stage[e], exp_done[e], exp_err[e]}) begin
        bad++;
        $display("FAIL midgap_restart edge %0d: got %b/%0d/%b/%b want %b/%0d/%b/%b", e,
                 obs_nrst[e], obs_stage[e], obs_done[e], obs_err[e], exp_nrst[e], exp_stage[e], exp_done[e], exp_err[e]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      clear_tabs();
      for (int e = 0; e <= MAXE; e++) begin
        for (int i = 0; i < NR; i++) ack_tab[e][i] = ($urandom_range(0, it + 1) == 0);
        sreq_tab[e] = (e > 3) && ($urandom_range(0, 39) == 0);
      end
      drive_scenario(90);
      build_expect(90);
      for (int e = 0; e <= 90; e++) begin
        total++;
        if ({obs_nrst[e], obs_stage[e], obs_done[e], obs_err[e]} !== {exp_nrst[e], exp_stage[e], exp_done[e], exp_err[e]}) begin
          bad++;
          $display("FAIL random it %0d edge %0d: got %b/%0d/%b/%b want %b/%0d/%b/%b", it, e,
                   obs_nrst[e], obs_stage[e], obs_done[e], obs_err[e], exp_nrst[e], exp_stage[e], exp_done[e], exp_err[e]);
        end
      end
    end
  endtask

  initial begin
    bus.sreq = 1'b0;
    bus.ack  = '0;
    test_reset();
    test_no_stall();
    test_ack_stall();
    test_ack_timeout();
    test_sreq_pulse();
    test_sreq_hold();
    test_nreset_midgap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
